hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have one clock port, clk, 1-bit input, rising-edge active.
REQ-002 The module SHALL have one reset port, reset, 1-bit input, asynchronous and active-high.
REQ-003 id_valid  in  1  ID stage holds a real instruction.
REQ-004 id_ra, id_rb  in  5 each  ID source register numbers (Reg2Loc already applied).
REQ-005 id_uses_ra, id_uses_rb  in  1 each  ID instruction reads that port.
REQ-006 id_reads_flags  in  1  ID instruction is a conditional branch on flags (BLT-class).
REQ-007 ex_valid  in  1  EX stage holds a real instruction.
REQ-008 ex_rd  in  5  EX destination register.
REQ-009 ex_regwrite, ex_memtoreg, ex_setflag  in  1 each  EX control bits.
REQ-010 ex_pc_select  in  1  EX branch outcome (PC redirect).
REQ-011 cnt_clear  in  1  synchronous clear of the performance counters.
REQ-012 pc_write, ifid_write  out  1 each  enable the PC and IF/ID registers.
REQ-013 ifid_flush, idex_bubble  out  1 each  squash IF/ID; inject a NOP into ID/EX.
REQ-014 state  out  2  current FSM state, encoded RUN=0, STALL=1, FLUSH=2.
REQ-015 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-016 load_use SHALL be 1 when all of the following hold:
- id_valid & ex_valid & ex_memtoreg & ex_regwrite;
- ex_rd != 31;
- (id_uses_ra & id_ra==ex_rd) | (id_uses_rb & id_rb==ex_rd).
REQ-017 flag_use SHALL be 1 when id_valid & id_reads_flags & ex_valid & ex_setflag; flags become usable one cycle after the setting instruction leaves EX.
REQ-018 br SHALL be 1 when ex_valid & ex_pc_select and state != FLUSH.
REQ-019 Priority SHALL be br > load_use > flag_use.
REQ-020 The FSM SHALL be RUN, STALL or FLUSH; state register updates on the rising clk edge.
REQ-021 RUN transitions:
- br -> FLUSH;
- else load_use|flag_use -> STALL;
- else stay RUN.
REQ-022 STALL and FLUSH SHALL each last exactly one cycle, then evaluate as RUN; from STALL a br moves to FLUSH, otherwise the FSM goes to RUN.
REQ-023 FLUSH SHALL ignore ex_pc_select (EX holds a squashed slot) and evaluate only load_use/flag_use.
REQ-024 Outputs SHALL be combinational from the current cycle's decision:
- br -> ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1;
- hazard -> pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0;
- none -> pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-025 ifid_flush and a freeze (pc_write=0) SHALL never be asserted in the same cycle.
REQ-026 stall_cnt SHALL increment by 1 on each edge where a hazard stall is issued; flush_cnt SHALL increment on each edge where br=1.
REQ-027 Both counters SHALL saturate at 16'hFFFF (no wrap).
REQ-028 cnt_clear SHALL zero both counters on that edge and SHALL take priority over a same-cycle increment.
REQ-029 The latency from hazard detection to output SHALL be zero cycles; the decision is registered into state on the same edge.

Reset
REQ-030 While reset=1, the module SHALL hold state=RUN, stall_cnt=0, flush_cnt=0 immediately, independent of clk.
REQ-031 While reset=1, the outputs SHALL be pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, regardless of other inputs.
REQ-032 Reset asserted mid-STALL or mid-FLUSH SHALL abort that state; the first post-reset cycle SHALL evaluate as RUN.

Structure
REQ-033 A shared package SHALL hold:
- the state enum (RUN/STALL/FLUSH);
- constant ZERO_REG=31;
- counter width CNT_W=16.
REQ-034 One sub-module, sat_counter (parameter width, inputs inc/clr, saturating), SHALL be instantiated twice.

Verification
REQ-035 Load ex_rd=5 with id_ra=5 and id_uses_ra=1 -> one cycle of pc_write=0, idex_bubble=1, state=STALL, stall_cnt=1.
REQ-036 Same as REQ-035 with ex_rd=31 -> no stall, counters unchanged.
REQ-037 ex_setflag=1 with id_reads_flags=1 -> one STALL cycle; the same with ex_valid=0 -> no stall.
REQ-038 ex_pc_select=1 together with a load_use condition -> ifid_flush=1, idex_bubble=1, pc_write=1, state=FLUSH, flush_cnt=1, stall_cnt=0.
REQ-039 ex_pc_select held high for 2 cycles -> exactly one flush counted (second cycle ignored in FLUSH).
REQ-040 Force stall_cnt to 16'hFFFF, then stall -> stays 16'hFFFF; cnt_clear with a simultaneous stall -> 0; reset asserted asynchronously mid-STALL -> state=RUN before the next edge.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the hardwired-zero register number and the counter width.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Per-cycle decision; exactly one applies in any cycle.
  typedef enum logic [1:0] {
    DEC_NONE  = 2'd0,
    DEC_STALL = 2'd1,
    DEC_FLUSH = 2'd2
  } decision_t;

  localparam logic [4:0] ZERO_REG = 5'd31;
  localparam int         CNT_W    = 16;

  // Source register match against an EX destination; unused ports never match.
  function automatic logic src_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
// Clear wins over a same-cycle increment; the count sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and flag-use stalls, branch flushes,
// a RUN/STALL/FLUSH FSM and saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_ra,
  input  logic [4:0]  id_rb,
  input  logic        id_uses_ra,
  input  logic        id_uses_rb,
  input  logic        id_reads_flags,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic        ex_setflag,
  input  logic        ex_pc_select,
  input  logic        cnt_clear,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  state_t    state_q;
  state_t    state_d;
  decision_t dec;
  logic      load_use;
  logic      flag_use;
  logic      br;
  logic      hazard;

  // Hazard detection is purely combinational so the reaction is same-cycle.
  always_comb begin
    load_use = id_valid && ex_valid && ex_memtoreg && ex_regwrite &&
               (ex_rd != ZERO_REG) &&
               (src_match(id_uses_ra, id_ra, ex_rd) ||
                src_match(id_uses_rb, id_rb, ex_rd));
    flag_use = id_valid && id_reads_flags && ex_valid && ex_setflag;
    // In FLUSH the EX slot was squashed, so its redirect must be ignored.
    br       = ex_valid && ex_pc_select && (state_q != ST_FLUSH);
    hazard   = load_use || flag_use;
  end

  // Valid/ready style contract: pc_write/ifid_write act as the "ready" of the
  // front end; they drop only for a stall, never together with ifid_flush.
  always_comb begin
    dec         = DEC_NONE;
    state_d     = ST_RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    unique case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (br) begin
          dec     = DEC_FLUSH;
          state_d = ST_FLUSH;
        end else if (hazard) begin
          dec     = DEC_STALL;
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        // A stall holds for a single cycle; only a redirect can follow it.
        if (br) begin
          dec     = DEC_FLUSH;
          state_d = ST_FLUSH;
        end
      end
      default: begin
        dec     = DEC_NONE;
        state_d = ST_RUN;
      end
    endcase

    if (reset) begin
      dec     = DEC_NONE;
      state_d = ST_RUN;
    end

    unique case (dec)
      DEC_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      DEC_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (dec == DEC_STALL),
    .clr   (cnt_clear),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (dec == DEC_FLUSH),
    .clr   (cnt_clear),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step pushes the expected outputs, state
// and counters for the cycle, then pops and compares them on the falling edge.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_ra;
  logic [4:0]  id_rb;
  logic        id_uses_ra;
  logic        id_uses_rb;
  logic        id_reads_flags;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  logic        ex_setflag;
  logic        ex_pc_select;
  logic        cnt_clear;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int errors = 0;
  int checks = 0;

  // Expected entry: {pc_write, ifid_write, ifid_flush, idex_bubble, state, stall_cnt, flush_cnt}
  logic [37:0] exp_q[$];

  localparam logic [3:0] O_NONE  = 4'b1100;
  localparam logic [3:0] O_STALL = 4'b0001;
  localparam logic [3:0] O_FLUSH = 4'b1111;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  hazard_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_ra          (id_ra),
    .id_rb          (id_rb),
    .id_uses_ra     (id_uses_ra),
    .id_uses_rb     (id_uses_rb),
    .id_reads_flags (id_reads_flags),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .ex_regwrite    (ex_regwrite),
    .ex_memtoreg    (ex_memtoreg),
    .ex_setflag     (ex_setflag),
    .ex_pc_select   (ex_pc_select),
    .cnt_clear      (cnt_clear),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .state          (state),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive_idle();
    id_valid       = 1'b0;
    id_ra          = 5'd0;
    id_rb          = 5'd0;
    id_uses_ra     = 1'b0;
    id_uses_rb     = 1'b0;
    id_reads_flags = 1'b0;
    ex_valid       = 1'b0;
    ex_rd          = 5'd0;
    ex_regwrite    = 1'b0;
    ex_memtoreg    = 1'b0;
    ex_setflag     = 1'b0;
    ex_pc_select   = 1'b0;
    cnt_clear      = 1'b0;
  endtask

  task automatic drive_load_use(input logic [4:0] rd, input logic [4:0] ra);
    drive_idle();
    id_valid    = 1'b1;
    id_ra       = ra;
    id_uses_ra  = 1'b1;
    ex_valid    = 1'b1;
    ex_rd       = rd;
    ex_regwrite = 1'b1;
    ex_memtoreg = 1'b1;
  endtask

  task automatic drive_flag_use(input logic exv);
    drive_idle();
    id_valid       = 1'b1;
    id_reads_flags = 1'b1;
    ex_valid       = exv;
    ex_setflag     = 1'b1;
  endtask

  // Scoreboard compare
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag, input logic [3:0] o, input logic [1:0] s,
                           input logic [15:0] sc, input logic [15:0] fc);
    check({tag, ".outs"},  {12'd0, pc_write, ifid_write, ifid_flush, idex_bubble}, {12'd0, o});
    check({tag, ".state"}, {14'd0, state}, {14'd0, s});
    check({tag, ".stall"}, stall_cnt, sc);
    check({tag, ".flush"}, flush_cnt, fc);
  endtask

  // Inputs must already be driven; compares on the falling edge, returns just after the next rising edge.
  task automatic cycle(input string tag, input logic [3:0] o, input logic [1:0] s,
                       input logic [15:0] sc, input logic [15:0] fc);
    logic [37:0] e;
    exp_q.push_back({o, s, sc, fc});
    @(negedge clk);
    e = exp_q.pop_front();
    check_now(tag, e[37:34], e[33:32], e[31:16], e[15:0]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    // Outputs forced to pass-through while in reset even with a hazard and a redirect present.
    drive_load_use(5'd5, 5'd5);
    ex_pc_select = 1'b1;
    #1;
    check_now("in_reset", O_NONE, S_RUN, 16'd0, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_idle();

    cycle("idle",          O_NONE,  S_RUN,   16'd0, 16'd0);
    drive_load_use(5'd5, 5'd5);
    cycle("lu_detect",     O_STALL, S_RUN,   16'd0, 16'd0);
    cycle("lu_held",       O_NONE,  S_STALL, 16'd1, 16'd0);
    drive_load_use(5'd31, 5'd31);
    cycle("lu_zero_reg",   O_NONE,  S_RUN,   16'd1, 16'd0);
    drive_flag_use(1'b1);
    cycle("flag_use",      O_STALL, S_RUN,   16'd1, 16'd0);
    drive_idle();
    cycle("after_flag",    O_NONE,  S_STALL, 16'd2, 16'd0);
    drive_flag_use(1'b0);
    cycle("flag_no_exv",   O_NONE,  S_RUN,   16'd2, 16'd0);
    drive_idle();
    cnt_clear = 1'b1;
    cycle("clear",         O_NONE,  S_RUN,   16'd2, 16'd0);

    // Branch beats a load-use through port rb.
    drive_load_use(5'd7, 5'd7);
    id_uses_ra   = 1'b0;
    id_rb        = 5'd7;
    id_uses_rb   = 1'b1;
    ex_pc_select = 1'b1;
    cycle("br_over_lu",    O_FLUSH, S_RUN,   16'd0, 16'd0);
    drive_idle();
    ex_valid     = 1'b1;
    ex_pc_select = 1'b1;
    cycle("br_in_flush",   O_NONE,  S_FLUSH, 16'd0, 16'd1);
    drive_idle();
    cycle("after_flush",   O_NONE,  S_RUN,   16'd0, 16'd1);

    drive_load_use(5'd3, 5'd3);
    cycle("lu_again",      O_STALL, S_RUN,   16'd0, 16'd1);
    drive_idle();
    ex_valid     = 1'b1;
    ex_pc_select = 1'b1;
    cycle("br_from_stall", O_FLUSH, S_STALL, 16'd1, 16'd1);
    drive_load_use(5'd9, 5'd9);
    ex_pc_select = 1'b1;
    cycle("lu_in_flush",   O_STALL, S_FLUSH, 16'd1, 16'd2);
    drive_idle();
    cycle("back_to_run",   O_NONE,  S_STALL, 16'd2, 16'd2);

    // Saturation: preload the stall counter to its maximum.
    force dut.u_stall_cnt.count = 16'hFFFF;
    #1;
    release dut.u_stall_cnt.count;
    drive_load_use(5'd12, 5'd12);
    cycle("sat_stall",     O_STALL, S_RUN,   16'hFFFF, 16'd2);
    drive_idle();
    cycle("sat_hold",      O_NONE,  S_STALL, 16'hFFFF, 16'd2);
    drive_load_use(5'd12, 5'd12);
    cnt_clear = 1'b1;
    cycle("clr_vs_stall",  O_STALL, S_RUN,   16'hFFFF, 16'd2);
    drive_idle();
    cycle("after_clr",     O_NONE,  S_STALL, 16'd0, 16'd0);

    // Asynchronous reset in the middle of a STALL cycle.
    drive_load_use(5'd20, 5'd20);
    cycle("pre_reset",     O_STALL, S_RUN,   16'd0, 16'd0);
    check_now("mid_stall", O_NONE, S_STALL, 16'd1, 16'd0);
    #2;
    ex_pc_select = 1'b1;
    reset = 1'b1;
    #1;
    check_now("async_rst", O_NONE, S_RUN, 16'd0, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_idle();
    cycle("post_reset",    O_NONE,  S_RUN,   16'd0, 16'd0);
    drive_load_use(5'd1, 5'd1);
    cycle("post_rst_lu",   O_STALL, S_RUN,   16'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
